regfile_mp_sb: RTL and testbench

- Parametrised multi-port integer register file for the NPC core.
- Configurable numbers of read and write ports, optional write-to-read bypass, a per-register pending scoreboard for pipelined issue, and a streaming dump engine that serialises all registers over a valid/ready channel for DiffTest.
- Sits between decode/issue (read ports, scoreboard set) and writeback (write ports, scoreboard clear).

---
 rtl/regfile_mp_sb_if.sv | 34 +++
 rtl/regfile_mp_sb.sv | 127 ++++++++++++
 tb/tb_regfile_mp_sb.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/regfile_mp_sb_if.sv
// Bus bundle for the multi-port register file: write/read ports, scoreboard set,
// and the streaming dump channel.
interface regfile_mp_sb_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 1
);
  logic [NUM_WR-1:0]            wen;
  logic [NUM_WR*ADDR_WIDTH-1:0] waddr;
  logic [NUM_WR*DATA_WIDTH-1:0] wdata;
  logic [NUM_RD*ADDR_WIDTH-1:0] raddr;
  logic [NUM_RD*DATA_WIDTH-1:0] rdata;
  logic [NUM_RD-1:0]            rbusy;
  logic                         sb_set;
  logic [ADDR_WIDTH-1:0]        sb_addr;
  logic                         dump_req;
  logic                         dump_valid;
  logic                         dump_ready;
  logic [ADDR_WIDTH-1:0]        dump_idx;
  logic [DATA_WIDTH-1:0]        dump_data;
  logic                         dump_last;
  logic                         dump_done;

  modport master (
    output wen, waddr, wdata, raddr, sb_set, sb_addr, dump_req, dump_ready,
    input  rdata, rbusy, dump_valid, dump_idx, dump_data, dump_last, dump_done
  );

  modport slave (
    input  wen, waddr, wdata, raddr, sb_set, sb_addr, dump_req, dump_ready,
    output rdata, rbusy, dump_valid, dump_idx, dump_data, dump_last, dump_done
  );
endinterface

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with optional write bypass, pending scoreboard
// and a valid/ready dump engine that streams every register in index order.
module regfile_mp_sb #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 1,
  parameter int BYPASS     = 1
) (
  input logic            clk,
  input logic            rst,
  regfile_mp_sb_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  logic [DATA_WIDTH-1:0] rf_q [DEPTH];
  logic [DATA_WIDTH-1:0] rf_d [DEPTH];
  logic [DEPTH-1:0]      pend_q, pend_d;
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] dump_idx_q, dump_idx_d;
  logic                  dump_done_q, dump_done_d;

  logic [ADDR_WIDTH-1:0] wa [NUM_WR];
  logic [DATA_WIDTH-1:0] wd [NUM_WR];
  logic [ADDR_WIDTH-1:0] ra [NUM_RD];
  logic [NUM_RD*DATA_WIDTH-1:0] rdata_c;
  logic [NUM_RD-1:0]            rbusy_c;

  for (genvar k = 0; k < NUM_WR; k++) begin : g_wr
    assign wa[k] = bus.waddr[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign wd[k] = bus.wdata[k*DATA_WIDTH +: DATA_WIDTH];
  end

  for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
    assign ra[j] = bus.raddr[j*ADDR_WIDTH +: ADDR_WIDTH];
  end

  // Ascending port loop makes the highest-numbered port win on index conflicts.
  always_comb begin
    rf_d = rf_q;
    for (int k = 0; k < NUM_WR; k++) begin
      if (bus.wen[k] && (wa[k] != '0)) rf_d[wa[k]] = wd[k];
    end
  end

  // Clears applied before the set so a same-cycle issue keeps the bit pending.
  always_comb begin
    pend_d = pend_q;
    for (int k = 0; k < NUM_WR; k++) begin
      if (bus.wen[k]) pend_d[wa[k]] = 1'b0;
    end
    if (bus.sb_set && (bus.sb_addr != '0)) pend_d[bus.sb_addr] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_comb begin
    rdata_c = '0;
    rbusy_c = '0;
    for (int j = 0; j < NUM_RD; j++) begin
      rdata_c[j*DATA_WIDTH +: DATA_WIDTH] = rf_q[ra[j]];
      if (BYPASS != 0) begin
        for (int k = 0; k < NUM_WR; k++) begin
          if (bus.wen[k] && (wa[k] == ra[j])) rdata_c[j*DATA_WIDTH +: DATA_WIDTH] = wd[k];
        end
      end
      if (ra[j] == '0) rdata_c[j*DATA_WIDTH +: DATA_WIDTH] = '0;
      rbusy_c[j] = pend_q[ra[j]];
    end
  end

  assign bus.rdata = rdata_c;
  assign bus.rbusy = rbusy_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) rf_q[i] <= '0;
      pend_q      <= '0;
      state_q     <= S_IDLE;
      dump_idx_q  <= '0;
      dump_done_q <= 1'b0;
    end else begin
      rf_q        <= rf_d;
      pend_q      <= pend_d;
      state_q     <= state_d;
      dump_idx_q  <= dump_idx_d;
      dump_done_q <= dump_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    dump_idx_d  = dump_idx_q;
    dump_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.dump_req) begin
          state_d    = S_STREAM;
          dump_idx_d = '0;
        end
      end
      S_STREAM: begin
        if (bus.dump_ready) begin
          if (dump_idx_q == LAST_IDX) begin
            state_d     = S_IDLE;
            dump_idx_d  = '0;
            dump_done_d = 1'b1;
          end else begin
            dump_idx_d = dump_idx_q + ADDR_WIDTH'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Beat data is read live from the array so writes before acceptance show up.
  always_comb begin
    bus.dump_valid = (state_q == S_STREAM);
    bus.dump_idx   = dump_idx_q;
    bus.dump_data  = rf_q[dump_idx_q];
    bus.dump_last  = (state_q == S_STREAM) && (dump_idx_q == LAST_IDX);
    bus.dump_done  = dump_done_q;
  end
endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb: a 2-write-port bypassing instance plus a
// non-bypassing instance for the registered-read behaviour.
module tb_regfile_mp_sb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_mp_sb_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_RD(2), .NUM_WR(2)) ifa ();
  regfile_mp_sb_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_RD(2), .NUM_WR(1)) ifb ();

  regfile_mp_sb #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_RD(2), .NUM_WR(2), .BYPASS(1))
    dut_a (.clk(clk), .rst(rst), .bus(ifa));
  regfile_mp_sb #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_RD(2), .NUM_WR(1), .BYPASS(0))
    dut_b (.clk(clk), .rst(rst), .bus(ifb));

  typedef struct packed {
    logic [1:0]  wen;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic [4:0]  ra0, ra1;
    logic        sb;
    logic [4:0]  sba;
    logic [31:0] e0, e1;
    logic [1:0]  eb;
  } vec_t;

  int total = 0;
  int bad = 0;
  vec_t vt [19];
  logic [31:0] mrf [32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_idx;
    bit done_exp, got_done, wrote, wr_now, rdy;

    ifa.wen = '0; ifa.waddr = '0; ifa.wdata = '0; ifa.raddr = '0;
    ifa.sb_set = 1'b0; ifa.sb_addr = '0; ifa.dump_req = 1'b0; ifa.dump_ready = 1'b0;
    ifb.wen = '0; ifb.waddr = '0; ifb.wdata = '0; ifb.raddr = '0;
    ifb.sb_set = 1'b0; ifb.sb_addr = '0; ifb.dump_req = 1'b0; ifb.dump_ready = 1'b0;
    for (int i = 0; i < 32; i++) mrf[i] = '0;

    //        wen   wa0   wa1   wd0           wd1        ra0   ra1   sb    sba   e0            e1            eb
    vt[0]  = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,     5'd5, 5'd3, 1'b0, 5'd0, 32'h0,        32'h0,        2'b00};
    vt[1]  = '{2'b01, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0,     5'd5, 5'd5, 1'b0, 5'd0, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00};
    vt[2]  = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,     5'd5, 5'd0, 1'b0, 5'd0, 32'hDEADBEEF, 32'h0,        2'b00};
    vt[3]  = '{2'b11, 5'd7, 5'd7, 32'h11,       32'h22,    5'd7, 5'd5, 1'b0, 5'd0, 32'h22,       32'hDEADBEEF, 2'b00};
    vt[4]  = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,     5'd7, 5'd7, 1'b0, 5'd0, 32'h22,       32'h22,       2'b00};
    vt[5]  = '{2'b01, 5'd0, 5'd0, 32'hFFFFFFFF, 32'h0,     5'd0, 5'd7, 1'b0, 5'd0, 32'h0,        32'h22,       2'b00};
    vt[6]  = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,     5'd0, 5'd0, 1'b0, 5'd0, 32'h0,        32'h0,        2'b00};
    vt[7]  = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,     5'd0, 5'd3, 1'b1, 5'd3, 32'h0,        32'h0,        2'b00};
    vt[8]  = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,     5'd0, 5'd3, 1'b0, 5'd0, 32'h0,        32'h0,        2'b10};
    vt[9]  = '{2'b01, 5'd3, 5'd0, 32'h33,       32'h0,     5'd0, 5'd3, 1'b0, 5'd0, 32'h0,        32'h33,       2'b10};
    vt[10] = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,     5'd0, 5'd3, 1'b0, 5'd0, 32'h0,        32'h33,       2'b00};
    vt[11] = '{2'b10, 5'd3, 5'd3, 32'hBAD,      32'h44,    5'd3, 5'd3, 1'b1, 5'd3, 32'h44,       32'h44,       2'b00};
    vt[12] = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,     5'd3, 5'd3, 1'b0, 5'd0, 32'h44,       32'h44,       2'b11};
    vt[13] = '{2'b01, 5'd3, 5'd0, 32'h55,       32'h0,     5'd3, 5'd3, 1'b0, 5'd0, 32'h55,       32'h55,       2'b11};
    vt[14] = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,     5'd3, 5'd3, 1'b0, 5'd0, 32'h55,       32'h55,       2'b00};
    vt[15] = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,     5'd0, 5'd0, 1'b1, 5'd0, 32'h0,        32'h0,        2'b00};
    vt[16] = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,     5'd0, 5'd0, 1'b0, 5'd0, 32'h0,        32'h0,        2'b00};
    vt[17] = '{2'b11, 5'd8, 5'd9, 32'h88,       32'h99,    5'd8, 5'd9, 1'b0, 5'd0, 32'h88,       32'h99,       2'b00};
    vt[18] = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,     5'd9, 5'd8, 1'b0, 5'd0, 32'h99,       32'h88,       2'b00};

    repeat (2) @(posedge clk);
    #1;
    ifa.raddr = {5'd7, 5'd5};
    #1;
    chk("rst_valid", ifa.dump_valid, 0);
    chk("rst_rdata", ifa.rdata[63:32] | ifa.rdata[31:0], 0);
    chk("rst_rbusy", ifa.rbusy, 0);
    rst = 1'b0;

    // Full dump after reset with ready held high.
    ifa.dump_req = 1'b1; ifa.dump_ready = 1'b1;
    #1 chk("d1_idle_valid", ifa.dump_valid, 0);
    step();
    ifa.dump_req = 1'b0;
    for (int i = 0; i < 32; i++) begin
      #1;
      chk($sformatf("d1_valid[%0d]", i), ifa.dump_valid, 1);
      chk($sformatf("d1_idx[%0d]", i), ifa.dump_idx, i);
      chk($sformatf("d1_data[%0d]", i), ifa.dump_data, 0);
      chk($sformatf("d1_last[%0d]", i), ifa.dump_last, (i == 31));
      chk($sformatf("d1_done[%0d]", i), ifa.dump_done, 0);
      step();
    end
    #1;
    chk("d1_done_pulse", ifa.dump_done, 1);
    chk("d1_end_valid", ifa.dump_valid, 0);
    chk("d1_end_idx", ifa.dump_idx, 0);
    step();
    chk("d1_done_clear", ifa.dump_done, 0);
    ifa.dump_ready = 1'b0;

    // Non-bypassing instance: write visible only the following cycle.
    ifb.wen = 1'b1; ifb.waddr = 5'd5; ifb.wdata = 32'hDEADBEEF; ifb.raddr = {5'd0, 5'd5};
    #1 chk("nobyp_same_cycle", ifb.rdata[31:0], 0);
    step();
    ifb.wen = 1'b0;
    #1 chk("nobyp_next_cycle", ifb.rdata[31:0], 32'hDEADBEEF);

    for (int i = 0; i < 19; i++) begin
      ifa.wen = vt[i].wen;
      ifa.waddr = {vt[i].wa1, vt[i].wa0};
      ifa.wdata = {vt[i].wd1, vt[i].wd0};
      ifa.raddr = {vt[i].ra1, vt[i].ra0};
      ifa.sb_set = vt[i].sb;
      ifa.sb_addr = vt[i].sba;
      #1;
      chk($sformatf("vec%0d_rdata0", i), ifa.rdata[31:0], vt[i].e0);
      chk($sformatf("vec%0d_rdata1", i), ifa.rdata[63:32], vt[i].e1);
      chk($sformatf("vec%0d_rbusy", i), ifa.rbusy, vt[i].eb);
      if (vt[i].wen[0] && vt[i].wa0 != 0) mrf[vt[i].wa0] = vt[i].wd0;
      if (vt[i].wen[1] && vt[i].wa1 != 0) mrf[vt[i].wa1] = vt[i].wd1;
      step();
    end
    ifa.wen = '0; ifa.sb_set = 1'b0; ifa.sb_addr = '0;

    // Dump with stalling ready, a late write to x10 and an ignored mid-stream request.
    ifa.dump_req = 1'b1;
    step();
    ifa.dump_req = 1'b0;
    exp_idx = 0; done_exp = 0; got_done = 0; wrote = 0;
    for (int cyc = 0; cyc < 200 && !got_done; cyc++) begin
      rdy = ((cyc % 3) != 1);
      ifa.dump_ready = rdy;
      ifa.dump_req = (exp_idx == 15);
      wr_now = (exp_idx == 8) && !wrote;
      ifa.wen = wr_now ? 2'b01 : 2'b00;
      ifa.waddr = {5'd0, 5'd10};
      ifa.wdata = {32'h0, 32'h0000ABCD};
      if (wr_now) wrote = 1;
      #1;
      if (done_exp) begin
        chk("d2_done_pulse", ifa.dump_done, 1);
        chk("d2_end_valid", ifa.dump_valid, 0);
        got_done = 1;
      end else begin
        chk($sformatf("d2_valid[%0d]", cyc), ifa.dump_valid, 1);
        chk($sformatf("d2_idx[%0d]", cyc), ifa.dump_idx, exp_idx);
        chk($sformatf("d2_data[%0d]", cyc), ifa.dump_data, mrf[exp_idx]);
        chk($sformatf("d2_last[%0d]", cyc), ifa.dump_last, (exp_idx == 31));
        chk($sformatf("d2_done[%0d]", cyc), ifa.dump_done, 0);
        if (exp_idx == 10) chk("d2_beat10_late_write", ifa.dump_data, 32'h0000ABCD);
      end
      step();
      if (wr_now) mrf[10] = 32'h0000ABCD;
      if (rdy && !done_exp) begin
        if (exp_idx == 31) done_exp = 1;
        else exp_idx++;
      end
    end
    if (!got_done) chk("d2_timeout", 0, 1);
    ifa.wen = '0; ifa.dump_req = 1'b0;

    // Reset in the middle of a dump, with x4 pending.
    ifa.sb_set = 1'b1; ifa.sb_addr = 5'd4; ifa.dump_req = 1'b1; ifa.dump_ready = 1'b1;
    step();
    ifa.sb_set = 1'b0; ifa.dump_req = 1'b0;
    repeat (12) step();
    ifa.raddr = {5'd4, 5'd5};
    #1;
    chk("d3_pre_idx", ifa.dump_idx, 12);
    chk("d3_pre_rbusy", ifa.rbusy, 2'b10);
    chk("d3_pre_rdata0", ifa.rdata[31:0], 32'hDEADBEEF);
    rst = 1'b1;
    #1;
    chk("d3_rst_valid", ifa.dump_valid, 0);
    chk("d3_rst_idx", ifa.dump_idx, 0);
    chk("d3_rst_done", ifa.dump_done, 0);
    chk("d3_rst_rdata", ifa.rdata[63:32] | ifa.rdata[31:0], 0);
    chk("d3_rst_rbusy", ifa.rbusy, 0);
    ifa.raddr = {5'd7, 5'd3};
    #1 chk("d3_rst_rdata_b", ifa.rdata[63:32] | ifa.rdata[31:0], 0);
    step();
    rst = 1'b0;
    ifa.dump_req = 1'b1;
    step();
    ifa.dump_req = 1'b0;
    ifa.dump_ready = 1'b0;
    #1;
    chk("d3_restart_valid", ifa.dump_valid, 1);
    chk("d3_restart_idx", ifa.dump_idx, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
